shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
// PURPOSE
//   Parametrised sequential unsigned/signed multiplier with an integrated controller.
//   Uses shift-and-add at one multiplier bit per cycle, with optional early exit.
//   Replaces the repeated-addition datapath, which needed B cycles per product and an external FSM.
//   Sits on the arithmetic path behind a valid/ready operand port and a valid/ready result port.
// PARAMETERS
//   WIDTH       16  operand width in bits; product is 2*WIDTH bits
//   EARLY_EXIT  1   1: stop when the remaining multiplier bits are all zero; 0: always WIDTH iterations
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        operands a, b, is_signed are valid
//   in_ready   out  1        block can accept operands (high only in IDLE)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        1: a and b are two's complement; 0: unsigned
//   out_valid  out  1        product is valid
//   out_ready  in   1        consumer accepts the product
//   product    out  2*WIDTH  result, two's complement when is_signed=1
//   busy       out  1        high in CALC and DONE
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers cleared.
//   Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
//   States: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: in_valid&in_ready accepts the operands at that clock edge:
//     M <= |a| zero-extended to 2*WIDTH; Q <= |b|; P <= 0.
//     neg <= is_signed & (a[W-1]^b[W-1]); cnt <= WIDTH.
//     |x| = is_signed&x[W-1] ? -x : x, taken as unsigned WIDTH bits, so -2^(W-1) gives magnitude 2^(W-1).
//   CALC, each cycle:
//     if Q[0]: P <= P+M, computed mod 2^(2W), which cannot overflow.
//     M <= M<<1; Q <= Q>>1; cnt <= cnt-1.
//     Leave for DONE when cnt==1, or when EARLY_EXIT=1 and (Q>>1)==0.
//   Iteration count N:
//     EARLY_EXIT=0: N = WIDTH.
//     EARLY_EXIT=1: N = max(1, msb_index(|b|)+1); b=0 gives N=1.
//   Latency: out_valid rises N+1 clock edges after the accept edge.
//   On entering DONE: product <= neg ? -P : P (2*WIDTH-bit two's complement); out_valid=1.
//   DONE: product and out_valid stay stable until out_ready=1.
//     On an edge with out_ready=1: out_valid <= 0, state <= IDLE.
//   After DONE, product holds its last value until the next DONE.
//   in_ready=0 in CALC and DONE; in_valid is ignored there, with no queueing.
//     Back-to-back operation therefore costs one IDLE cycle per product.
//   out_ready outside DONE has no effect.
//   An is_signed change after accept has no effect; the mode is latched with the operands.
//   Corner case: signed -2^(W-1) x -2^(W-1) = +2^(2W-2), representable, exact.
//   Corner case: unsigned max x max = 2^(2W) - 2^(W+1) + 1, exact.
// STRUCTURE
//   Package mult_pkg:
//     - typedef enum {IDLE, CALC, DONE} mult_state_t
//     - localparam for the cnt width, $clog2(WIDTH+1)
//   Sub-module mult_ctrl: FSM, cnt, early-exit decision, handshake outputs.
//   Top: M/Q/P registers, magnitude conversion, adder, final negation.
// TESTING (WIDTH=16)
//   1. Unsigned 3 x 5, EARLY_EXIT=1 -> product=0x0000000F; out_valid 4 edges after accept (N=3).
//   2. Unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001 after 17 edges; repeat with EARLY_EXIT=0 for the same value and latency.
//   3. Signed 0x8000 x 0x8000 -> 0x40000000; signed 0xFFFD x 0x0007 -> 0xFFFFFFEB (-21).
//   4. a=1234, b=0 -> product=0 after 2 edges; a=0, b=0xFFFF with EARLY_EXIT=1 -> product=0 after 17 edges.
//   5. Hold out_ready=0 for 5 cycles in DONE, pulsing in_valid meanwhile:
//      -> out_valid and product stable, in_ready=0, no new operation starts; with out_ready=1 -> IDLE next edge.
//   6. Assert reset mid-CALC -> out_valid=0, busy=0, product=0 asynchronously;
//      the next operation 7 x 9 -> 63, correct.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
//   mult_state_t  : controller states
//   MULT_WIDTH    : default operand width
//   mult_cnt_w()  : iteration counter width, wide enough to hold WIDTH itself
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH = 16;

  function automatic int mult_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Controller for the shift-and-add multiplier: state machine, iteration
// down-counter, early-exit decision and valid/ready handshakes.
//   clk, reset    : clock, async active-high reset
//   in_valid      : operand offer from the producer
//   out_ready     : consumer accepts the product
//   q_rest_zero   : multiplier bits above Q[0] are all zero
//   in_ready      : high only in IDLE
//   out_valid     : product presented (DONE only)
//   busy          : high in CALC and DONE
//   accept        : load operands this edge
//   calc_en       : perform one shift-and-add iteration this edge
//   load_result   : capture the (possibly negated) product this edge
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one multiplier bit per cycle
// DONE  | first cycle captures product; then holds it until out_ready
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic out_ready,
  input  logic q_rest_zero,
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic accept,
  output logic calc_en,
  output logic load_result
);

  localparam int CNT_W = mult_cnt_w(WIDTH);

  mult_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    accept      = 1'b0;
    calc_en     = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(WIDTH);
          state_d = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1) || (EARLY_EXIT && q_rest_zero)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The negation gets its own cycle so it never chains onto the adder.
        if (!out_valid_q) begin
          load_result = 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;

endmodule

// File: rtl/shift_add_mult.sv
// Sequential signed/unsigned multiplier, one multiplier bit per cycle.
// Operands are converted to magnitudes on accept, multiplied unsigned, and
// the sign is reapplied once when the result is captured.
//   clk, reset           : clock, async active-high reset
//   in_valid / in_ready  : operand handshake (a, b, is_signed)
//   out_valid / out_ready: result handshake (product)
//   product              : 2*WIDTH-bit result, holds until the next result
//   busy                 : operation in progress (CALC or DONE)
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH      = MULT_WIDTH,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  logic [2*WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic accept, calc_en, load_result, q_rest_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  assign q_rest_zero = (q_q[WIDTH-1:1] == '0);

  mult_ctrl #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .q_rest_zero (q_rest_zero),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .busy        (busy),
    .accept      (accept),
    .calc_en     (calc_en),
    .load_result (load_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    m_d       = m_q;
    q_d       = q_q;
    p_d       = p_q;
    neg_d     = neg_q;
    product_d = product_q;
    if (accept) begin
      m_d   = {{WIDTH{1'b0}}, a_mag};
      q_d   = b_mag;
      p_d   = '0;
      neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end
    if (calc_en) begin
      if (q_q[0]) begin
        p_d = p_q + m_q;
      end
      m_d = m_q << 1;
      q_d = q_q >> 1;
    end
    if (load_result) begin
      product_d = neg_q ? (~p_q + 1'b1) : p_q;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset, in_valid, is_signed, out_ready;
  logic [W-1:0] a, b;

  logic in_ready_e, out_valid_e, busy_e;
  logic [2*W-1:0] product_e;
  logic in_ready_f, out_valid_f, busy_f;
  logic [2*W-1:0] product_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_e),
    .out_ready(out_ready), .product(product_e), .busy(busy_e)
  );

  shift_add_mult #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_f),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_f),
    .out_ready(out_ready), .product(product_f), .busy(busy_f)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product: plain integer multiplication, truncated to 2W bits.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic s);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return (2*W)'(xv * yv);
  endfunction

  // Edges from accept to out_valid with early exit: N+1, N = bit length of |b| (min 1).
  function automatic int ref_lat_e(input logic [W-1:0] y, input logic s);
    longint yv;
    int n;
    yv = s ? longint'($signed(y)) : longint'(y);
    if (yv < 0) yv = -yv;
    n = 1;
    while ((yv >> n) != 0) n++;
    return n + 1;
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    // Scramble operands and mode after accept; they must be latched.
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    is_signed = ~s;
  endtask

  task automatic wait_done(output int lat_e, output int lat_f);
    lat_e = 0;
    lat_f = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid_e && lat_e == 0) lat_e = cyc;
      if (out_valid_f && lat_f == 0) lat_f = cyc;
      if (lat_e != 0 && lat_f != 0) break;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " release e"}, {62'd0, out_valid_e, in_ready_e}, 64'b01);
    check({tag, " release f"}, {62'd0, out_valid_f, in_ready_f}, 64'b01);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s);
    int le, lf;
    logic [2*W-1:0] exp_p;
    exp_p = ref_prod(x, y, s);
    start_op(x, y, s);
    wait_done(le, lf);
    check({tag, " lat e"}, 64'(le), 64'(ref_lat_e(y, s)));
    check({tag, " lat f"}, 64'(lf), 64'(W + 1));
    check({tag, " prod e"}, 64'(product_e), 64'(exp_p));
    check({tag, " prod f"}, 64'(product_f), 64'(exp_p));
    release_out(tag);
  endtask

  initial begin
    int le, lf;
    logic [2*W-1:0] held;
    logic [W-1:0] ra, rb;
    logic rs;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
    a = '0; b = '0;
    #1;
    check("reset e", {29'd0, in_ready_e, out_valid_e, busy_e, product_e}, {29'd0, 3'b100, 32'd0});
    check("reset f", {29'd0, in_ready_f, out_valid_f, busy_f, product_f}, {29'd0, 3'b100, 32'd0});
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("u3x5", 16'd3, 16'd5, 1'b0);
    run_op("umax", 16'hFFFF, 16'hFFFF, 1'b0);
    run_op("smin", 16'h8000, 16'h8000, 1'b1);
    run_op("sneg", 16'hFFFD, 16'h0007, 1'b1);
    run_op("bzero", 16'd1234, 16'd0, 1'b0);
    run_op("azero", 16'd0, 16'hFFFF, 1'b0);
    run_op("s_a_pos_b_neg", 16'd300, 16'hFF00, 1'b1);

    // Hold the result while in_valid pulses; nothing new may start.
    start_op(16'd100, 16'd200, 1'b0);
    wait_done(le, lf);
    check("hold lat e", 64'(le), 64'(ref_lat_e(16'd200, 1'b0)));
    held = ref_prod(16'd100, 16'd200, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      check("hold state e", {60'd0, out_valid_e, in_ready_e, busy_e, 1'b0}, 64'b1010);
      check("hold prod e", 64'(product_e), 64'(held));
      check("hold state f", {60'd0, out_valid_f, in_ready_f, busy_f, 1'b0}, 64'b1010);
    end
    in_valid = 1'b0;
    release_out("hold");
    @(posedge clk);
    #1;
    check("idle after hold", {61'd0, in_ready_e, out_valid_e, busy_e}, 64'b100);
    check("prod kept e", 64'(product_e), 64'(held));
    check("prod kept f", 64'(product_f), 64'(held));

    // Reset in the middle of CALC.
    start_op(16'h1234, 16'h5678, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset e", {29'd0, in_ready_e, out_valid_e, busy_e, product_e}, {29'd0, 3'b100, 32'd0});
    check("midreset f", {29'd0, in_ready_f, out_valid_f, busy_f, product_f}, {29'd0, 3'b100, 32'd0});
    @(negedge clk);
    reset = 1'b0;
    run_op("7x9", 16'd7, 16'd9, 1'b0);

    // Randomized operands, with b often narrowed to exercise early exit.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom & ((32'd1 << $urandom_range(0, 16)) - 1));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
